// File: rtl/arbitrated_bus_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_bus_pkg
// Description : Shared definitions for the arbitrated tristate bus driver.
//               FSM state codes and the owner-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_bus_pkg;

    // FSM state encoding; code 2'b11 is illegal and recovers to IDLE.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_DRIVE = 2'b01;
    localparam logic [1:0] ST_TURN  = 2'b10;

    // Width of a channel index; never below one bit.
    function automatic int owner_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arbitrated_bus_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : arbitrated_bus_driver_if
// Description : Request/data/bus bundle between the data sources and the
//               arbitrated bus driver.
//   req        - per-channel request, held with data stable until ack
//   data_in    - packed channel words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack        - one-cycle grant pulse to the winning channel
//   bus_out    - shared tristate bus, z when not driven
//   bus_valid  - high while bus_out is driven
//   bus_owner  - index of current/last owner
//   busy       - driver is not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface arbitrated_bus_driver_if
    import arb_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4
) ();

    logic [NUM_CH-1:0]              req;
    logic [NUM_CH*DATA_WIDTH-1:0]   data_in;
    logic [NUM_CH-1:0]              ack;
    wire  [DATA_WIDTH-1:0]          bus_out;
    logic                           bus_valid;
    logic [owner_w(NUM_CH)-1:0]     bus_owner;
    logic                           busy;

    // Requester side
    modport master (
        output req, data_in,
        input  ack, bus_out, bus_valid, bus_owner, busy
    );

    // Bus driver side
    modport slave (
        input  req, data_in,
        output ack, bus_out, bus_valid, bus_owner, busy
    );

endinterface
`default_nettype wire

// File: rtl/arbitrated_bus_driver_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin search. Finds the first set req
//               bit at or above rr_ptr, wrapping from NUM_CH-1 to 0.
//   req     in  NUM_CH  request vector
//   rr_ptr  in  OW      search start index
//   found   out 1       any request present
//   winner  out OW      index of the chosen channel
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import arb_bus_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  wire logic [NUM_CH-1:0]          req,
    input  wire logic [owner_w(NUM_CH)-1:0] rr_ptr,
    output logic                            found,
    output logic [owner_w(NUM_CH)-1:0]      winner
);

    localparam int OW = owner_w(NUM_CH);

    logic [2*NUM_CH-1:0] w_dbl;
    logic [NUM_CH-1:0]   w_rot;
    logic [OW-1:0]       w_offset;
    logic [OW:0]         w_sum;

    // Doubling the vector turns the wrap-around search into a plain
    // lowest-set-bit search on the window starting at rr_ptr.
    always_comb begin
        w_dbl    = {req, req};
        w_rot    = NUM_CH'(w_dbl >> rr_ptr);
        found    = |req;
        w_offset = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_offset = OW'(i);
            end
        end
        w_sum = {1'b0, rr_ptr} + {1'b0, w_offset};
        if (w_sum >= (OW+1)'(NUM_CH)) begin
            w_sum = w_sum - (OW+1)'(NUM_CH);
        end
        winner = w_sum[OW-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/arbitrated_bus_driver.sv
`default_nettype none
// ============================================================================
// Module      : arbitrated_bus_driver
// Description : Round-robin arbitrated driver for a shared tristate data bus.
//               The winning word is captured at the grant edge and driven
//               for HOLD_CYCLES cycles, optionally followed by one high-Z
//               turnaround cycle.
//   clk      in   clock, rising edge
//   reset_n  in   synchronous active-low reset
//   bus      io   arbitrated_bus_driver_if.slave (req/data_in in; ack,
//                 bus_out, bus_valid, bus_owner, busy out)
// Revision    : 1.0 - initial release
// ============================================================================
module arbitrated_bus_driver
    import arb_bus_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int TURNAROUND  = 1
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    arbitrated_bus_driver_if.slave  bus
);

    localparam int           OW       = owner_w(NUM_CH);
    localparam int           CW       = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

    logic [1:0]            r_state;
    logic [OW-1:0]         r_rr_ptr;
    logic [DATA_WIDTH-1:0] r_hold_reg;
    logic [CW-1:0]         r_cnt;
    logic [OW-1:0]         r_owner;
    logic [NUM_CH-1:0]     r_ack;

    logic                  w_found;
    logic [OW-1:0]         w_winner;
    logic [OW-1:0]         w_next_ptr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_drive;

    rr_picker #(
        .NUM_CH (NUM_CH)
    ) u_rr_picker (
        .req    (bus.req),
        .rr_ptr (r_rr_ptr),
        .found  (w_found),
        .winner (w_winner)
    );

    always_comb begin
        w_next_ptr = (w_winner == OW'(NUM_CH - 1)) ? '0 : w_winner + 1'b1;
        w_sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_winner == OW'(i)) begin
                w_sel_data = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_hold_reg <= '0;
            r_cnt      <= '0;
            r_owner    <= '0;
            r_ack      <= '0;
        end else begin
            // ack is a single-cycle pulse aligned with the first DRIVE cycle.
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_hold_reg <= w_sel_data;
                        r_owner    <= w_winner;
                        r_rr_ptr   <= w_next_ptr;
                        r_cnt      <= CNT_LOAD;
                        r_ack      <= NUM_CH'(1) << w_winner;
                        r_state    <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (TURNAROUND != 0) begin
                        r_state <= ST_TURN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_TURN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // All outputs decode registered state only.
    assign w_drive       = (r_state == ST_DRIVE);
    assign bus.bus_out   = w_drive ? r_hold_reg : {DATA_WIDTH{1'bz}};
    assign bus.bus_valid = w_drive;
    assign bus.bus_owner = r_owner;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.ack       = r_ack;

endmodule
`default_nettype wire

// File: doc/arbitrated_bus_driver.md
# arbitrated_bus_driver

- Multi-source, clocked successor to a plain enable-gated tristate buffer.
- NUM_CH requesters compete for one shared tristate data bus; a round-robin arbiter picks one winner.
- The winner's word is captured into a holding register and driven for HOLD_CYCLES cycles, with an optional one-cycle high-Z turnaround between owners.
- Sits between peripheral/bridge data sources and a shared read-data bus in the CPU datapath.

## Interface
- DATA_WIDTH, 32, width of each data word and of the bus.
- NUM_CH, 4, number of requesting channels (2..16).
- HOLD_CYCLES, 1, cycles a granted word is driven (>=1).
- TURNAROUND, 1, 1 = insert one high-Z cycle after each drive; 0 = none.
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  reset is synchronous and active-low.
- req  in  NUM_CH  per-channel request; hold high with data stable until ack.
- data_in  in  NUM_CH*DATA_WIDTH  packed channel words; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- ack  out  NUM_CH  one-cycle pulse to the granted channel.
- bus_out  out  DATA_WIDTH  driven with captured word in DRIVE; all bits z otherwise.
- bus_valid  out  1  high exactly while bus_out is driven.
- bus_owner  out  max(1,$clog2(NUM_CH))  index of current/last owner.
- busy  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: bus z. If any req bit is high, pick a channel, capture its data into hold_reg, record it in bus_owner, load the hold counter with HOLD_CYCLES-1, and go to DRIVE.
  - DRIVE: bus_out = hold_reg, bus_valid = 1.
    - Counter > 0: decrement it.
    - Counter = 0: go to TURN if TURNAROUND = 1, else go to IDLE.
  - TURN: bus z, bus_valid = 0; go to IDLE.
- Arbitration happens only in IDLE.
  - Search starts at rr_ptr and runs upward with wrap-around (NUM_CH-1 wraps to 0); the first req bit found wins.
  - On each grant, rr_ptr becomes (winner+1) mod NUM_CH.
- ack[winner] is high only in the first DRIVE cycle. The requester drops req in that cycle or later.
  - A req still high when the block next reaches IDLE is treated as a new request; this is the legal way to stream words.
- req asserted during DRIVE or TURN is ignored until IDLE; it is not lost as long as it stays high.
- data_in is sampled only at the grant edge. Later changes do not affect the word on the bus.
- req = 0 in IDLE: stay in IDLE; bus_out stays z and bus_owner keeps its value.
- Reset values (reset_n low at an edge): state IDLE, rr_ptr 0, hold_reg 0, counter 0, bus_owner 0, ack 0, bus_valid 0, busy 0, bus_out all z.
- Reset mid-DRIVE: the bus releases to z after that edge, with no turnaround and no ack.

## Timing
- Request-to-bus latency:
  - Req high at the edge t while in IDLE: bus_out valid and ack high in cycle t+1.
  - Outputs are a function of registered state only; no combinational path from req to any output.
- Occupancy per grant: 1 IDLE + HOLD_CYCLES DRIVE + TURNAROUND TURN cycles.
  - Minimum repeat period: HOLD_CYCLES + TURNAROUND + 1.
- With TURNAROUND = 1, two different owners never drive in adjacent cycles; at least 2 z cycles (TURN plus IDLE) separate them.
- Counter width: $clog2(HOLD_CYCLES+1). With HOLD_CYCLES = 1 the counter is constant 0.

## Structure
- Shared package arb_bus_pkg:
  - State encoding: IDLE = 2'b00, DRIVE = 2'b01, TURN = 2'b10. Illegal code 2'b11 recovers to IDLE.
  - Owner-width helper constant.
- Sub-module rr_picker (purely combinational):
  - Inputs: req, rr_ptr.
  - Outputs: found, winner index.
  - Implemented as a doubled-vector priority search.
- Top level holds the FSM, hold counter, hold_reg, rr_ptr, and the conditional-z assignment on bus_out.

## Test plan
- Reset, NUM_CH = 4: hold reset_n low 2 cycles with req = 4'b1111 -> bus_out all z, bus_valid 0, ack 0, busy 0; the first grant after release goes to ch0.
- Single request, HOLD_CYCLES = 1, TURNAROUND = 1, ch2 data 32'hDEADBEEF:
  - Req at edge 0 -> cycle 1: bus_out = DEADBEEF, ack = 4'b0100, bus_owner = 2.
  - Cycle 2: z (TURN). Cycle 3: IDLE.
- All four channels held high, HOLD_CYCLES = 1, TURNAROUND = 1:
  - Grant order 0, 1, 2, 3, 0.
  - Each grant 3 cycles apart; acks one-hot, never overlapping.
- HOLD_CYCLES = 3, TURNAROUND = 0:
  - bus_valid high exactly 3 cycles per grant.
  - data_in changed during DRIVE -> bus_out keeps the captured word.
  - Back-to-back grants are separated by exactly 1 z cycle.
- Reset mid-DRIVE, HOLD_CYCLES = 4: reset_n low in the 2nd DRIVE cycle -> bus z on the next cycle, rr_ptr back to 0, and a pending ch3 request is granted as the first grant after release.
- Wrap-around: rr_ptr = 3 with req = 4'b0011 -> ch0 wins, then ch1 wins.
